dm_mem_stage: RTL

MEM-stage data memory with byte-lane store control and the MEM/WB output latch.
- Performs sw/sh/sb writes into a word-organised little-endian RAM.
- Reads the addressed word combinationally.
- Registers the read word, address low bits and load op for the WB-stage load extender. That extender takes Din, A[1:0] and Op[2:0], with Op: 0 lw, 1 lbu, 2 lb, 3 lhu, 4 lh.
- Detects misaligned and out-of-range accesses and reports them one cycle later with the data.

---
 rtl/dm_mem_stage.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dm_mem_stage.sv
// MEM-stage data memory: byte-lane stores into a word RAM, combinational read,
// and the MEM/WB latch that feeds the WB-stage load extender.
module dm_mem_stage #(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  st_op_i,
   input  logic [2:0]  ld_op_i,
   input  logic        ld_en_i,
   output logic [31:0] wb_din_o,
   output logic [1:0]  wb_a_o,
   output logic [2:0]  wb_op_o,
   output logic        wb_ld_o,
   output logic        wb_ades_o,
   output logic        wb_adel_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [31:0]           mem_q [DEPTH];
   logic [31:0]           off;
   logic                  in_range;
   logic [DEPTH_LOG2-1:0] idx;
   logic [31:0]           rd_word;
   logic                  st_mis;
   logic                  ld_mis;
   logic [3:0]            be;
   logic [31:0]           wlane;
   logic                  st_commit;

   logic [31:0] wb_din_q, wb_din_d;
   logic [1:0]  wb_a_q,   wb_a_d;
   logic [2:0]  wb_op_q,  wb_op_d;
   logic        wb_ld_q,  wb_ld_d;
   logic        wb_ades_q, wb_ades_d;
   logic        wb_adel_q, wb_adel_d;

   // Address decode: offset from base, range test done in 33 bits so the
   // bound never wraps for large DEPTH_LOG2.
   always_comb begin
      off      = addr_i - BASE_ADDR;
      in_range = ({1'b0, off} < (33'd4 << DEPTH_LOG2));
      idx      = off[DEPTH_LOG2+1:2];
      rd_word  = in_range ? mem_q[idx] : 32'h0;
   end

   // Alignment checks for the store and the load side separately.
   always_comb begin
      case (st_op_i)
         2'd1:    st_mis = (addr_i[1:0] != 2'b00);
         2'd2:    st_mis = addr_i[0];
         default: st_mis = 1'b0;
      endcase
      case (ld_op_i)
         3'd0:       ld_mis = (addr_i[1:0] != 2'b00);
         3'd3, 3'd4: ld_mis = addr_i[0];
         default:    ld_mis = 1'b0;
      endcase
   end

   // Byte enables and lane-replicated write data (little-endian lanes).
   always_comb begin
      be    = 4'b0000;
      wlane = wdata_i;
      case (st_op_i)
         2'd1: be = 4'b1111;
         2'd2: begin
            be    = addr_i[1] ? 4'b1100 : 4'b0011;
            wlane = {2{wdata_i[15:0]}};
         end
         2'd3: begin
            be    = 4'b0001 << addr_i[1:0];
            wlane = {4{wdata_i[7:0]}};
         end
         default: be = 4'b0000;
      endcase
      st_commit = (st_op_i != 2'd0) && !stall_i && !st_mis && in_range;
   end

   // Memory array: zeroed on reset, otherwise byte-masked store commit.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
      end else if (st_commit) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) mem_q[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
   end

   // MEM/WB next state: flush clears, stall holds, else capture this access.
   always_comb begin
      wb_din_d  = wb_din_q;
      wb_a_d    = wb_a_q;
      wb_op_d   = wb_op_q;
      wb_ld_d   = wb_ld_q;
      wb_ades_d = wb_ades_q;
      wb_adel_d = wb_adel_q;
      if (flush_i) begin
         wb_din_d  = 32'h0;
         wb_a_d    = 2'b00;
         wb_op_d   = 3'd0;
         wb_ld_d   = 1'b0;
         wb_ades_d = 1'b0;
         wb_adel_d = 1'b0;
      end else if (!stall_i) begin
         wb_din_d  = rd_word;
         wb_a_d    = addr_i[1:0];
         wb_op_d   = ld_op_i;
         wb_ld_d   = ld_en_i;
         wb_adel_d = ld_en_i & (ld_mis | !in_range);
         wb_ades_d = (st_op_i != 2'd0) & (st_mis | !in_range);
      end
   end

   // MEM/WB latch register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wb_din_q  <= 32'h0;
         wb_a_q    <= 2'b00;
         wb_op_q   <= 3'd0;
         wb_ld_q   <= 1'b0;
         wb_ades_q <= 1'b0;
         wb_adel_q <= 1'b0;
      end else begin
         wb_din_q  <= wb_din_d;
         wb_a_q    <= wb_a_d;
         wb_op_q   <= wb_op_d;
         wb_ld_q   <= wb_ld_d;
         wb_ades_q <= wb_ades_d;
         wb_adel_q <= wb_adel_d;
      end
   end

   assign wb_din_o  = wb_din_q;
   assign wb_a_o    = wb_a_q;
   assign wb_op_o   = wb_op_q;
   assign wb_ld_o   = wb_ld_q;
   assign wb_ades_o = wb_ades_q;
   assign wb_adel_o = wb_adel_q;

endmodule
